// File: rtl/alu_pkg.sv
// Shared opcode encoding for the execute-stage ALU.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'd0;
    localparam alu_op_t ALU_OR  = 4'd1;
    localparam alu_op_t ALU_ADD = 4'd2;
    localparam alu_op_t ALU_SUB = 4'd6;
    localparam alu_op_t ALU_SLT = 4'd7;
    localparam alu_op_t ALU_NOR = 4'd12;

endpackage

// File: rtl/alu_addsub.sv
// W-bit adder/subtractor: sub=1 computes A + ~B + 1, so carry=1 means A >= B.
module alu_addsub #(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] b_eff;

    assign b_eff = sub ? ~B : B;

    // One W+1-bit add; carry-in doubles as the two's-complement +1.
    assign {carry, sum} = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: one combinational opcode decode into a single output register.
// Result, carry-out and zero flag all come from the same next-state value.
module alu_unit
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [3:0]   ALU_ctrl,
    output logic [W-1:0] ALU_o,
    output logic         cout,
    output logic         zero
);

    logic [W-1:0] as_sum;
    logic         as_carry;
    logic         as_sub;

    logic [W-1:0] alu_d, alu_q;
    logic         cout_d, cout_q;
    logic         zero_d, zero_q;

    // SLT reuses the subtractor: A < B exactly when A - B borrows.
    assign as_sub = (ALU_ctrl == ALU_SUB) || (ALU_ctrl == ALU_SLT);

    alu_addsub #(.W(W)) u_addsub (
        .A     (A),
        .B     (B),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry)
    );

    // Opcode decode; unknown codes resolve to a clean zero result.
    always_comb begin
        alu_d  = '0;
        cout_d = 1'b0;
        case (ALU_ctrl)
            ALU_AND: alu_d = A & B;
            ALU_OR:  alu_d = A | B;
            ALU_ADD: begin
                alu_d  = as_sum;
                cout_d = as_carry;
            end
            ALU_SUB: begin
                alu_d  = as_sum;
                cout_d = as_carry;
            end
            ALU_SLT: alu_d = {{(W-1){1'b0}}, ~as_carry};
            ALU_NOR: alu_d = ~(A | B);
            default: begin
                alu_d  = '0;
                cout_d = 1'b0;
            end
        endcase
        zero_d = (alu_d == '0);
    end

    // Output register; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            alu_q  <= alu_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    assign ALU_o = alu_q;
    assign cout  = cout_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected results queued at drive time, popped after the edge.
module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B;
    logic [3:0]   ALU_ctrl;
    logic [W-1:0] ALU_o;
    logic         cout, zero;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        string        tag;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [3:0]   op;
        logic         rs;
        logic [W-1:0] r;
        logic         c, z;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    alu_unit #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_ctrl (ALU_ctrl),
        .ALU_o    (ALU_o),
        .cout     (cout),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Independent reference using wide integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
        exp_t e;
        int unsigned ai, bi, s;
        ai = a; bi = b;
        e.r = '0; e.c = 1'b0; e.tag = "random";
        case (op)
            4'd0:  e.r = a & b;
            4'd1:  e.r = a | b;
            4'd2:  begin s = ai + bi; e.r = s[W-1:0]; e.c = (s >= (1 << W)); end
            4'd6:  begin s = ai - bi; e.r = s[W-1:0]; e.c = (ai >= bi); end
            4'd7:  e.r = (ai < bi) ? 1 : 0;
            4'd12: e.r = ~(a | b);
            default: e.r = '0;
        endcase
        e.z = (e.r == 0);
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input logic rs, input exp_t e);
        @(negedge clk);
        A = a; B = b; ALU_ctrl = op; rst = rs;
        sb.push_back(e);
    endtask

    function automatic exp_t from_vec(input vec_t v, input string tag);
        exp_t e;
        e.r = v.r; e.c = v.c; e.z = v.z; e.tag = tag;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        apply(8'd200, 8'd100, ALU_ADD, 1'b1, from_vec('{8'd200, 8'd100, ALU_ADD, 1'b1, 8'd0, 1'b0, 1'b1}, "reset"));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++; if (ALU_o !== e.r) begin errors++; $display("FAIL %s ALU_o got %0d want %0d", e.tag, ALU_o, e.r); end
        checks++; if (cout !== e.c) begin errors++; $display("FAIL %s cout got %b want %b", e.tag, cout, e.c); end
        checks++; if (zero !== e.z) begin errors++; $display("FAIL %s zero got %b want %b", e.tag, zero, e.z); end
    endtask

    task automatic test_add();
        vec_t tv[2];
        exp_t e;
        tv = '{'{8'd200, 8'd100, ALU_ADD, 1'b0, 8'd44, 1'b1, 1'b0},
               '{8'd0,   8'd0,   ALU_ADD, 1'b0, 8'd0,  1'b0, 1'b1}};
        foreach (tv[i]) begin
            apply(tv[i].a, tv[i].b, tv[i].op, tv[i].rs, from_vec(tv[i], $sformatf("add%0d", i)));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (ALU_o !== e.r) begin errors++; $display("FAIL %s ALU_o got %0d want %0d", e.tag, ALU_o, e.r); end
            checks++; if (cout !== e.c) begin errors++; $display("FAIL %s cout got %b want %b", e.tag, cout, e.c); end
            checks++; if (zero !== e.z) begin errors++; $display("FAIL %s zero got %b want %b", e.tag, zero, e.z); end
        end
    endtask

    task automatic test_sub();
        vec_t tv[2];
        exp_t e;
        tv = '{'{8'd5, 8'd7, ALU_SUB, 1'b0, 8'd254, 1'b0, 1'b0},
               '{8'd9, 8'd9, ALU_SUB, 1'b0, 8'd0,   1'b1, 1'b1}};
        foreach (tv[i]) begin
            apply(tv[i].a, tv[i].b, tv[i].op, tv[i].rs, from_vec(tv[i], $sformatf("sub%0d", i)));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (ALU_o !== e.r) begin errors++; $display("FAIL %s ALU_o got %0d want %0d", e.tag, ALU_o, e.r); end
            checks++; if (cout !== e.c) begin errors++; $display("FAIL %s cout got %b want %b", e.tag, cout, e.c); end
            checks++; if (zero !== e.z) begin errors++; $display("FAIL %s zero got %b want %b", e.tag, zero, e.z); end
        end
    endtask

    task automatic test_slt();
        vec_t tv[3];
        exp_t e;
        tv = '{'{8'd3,   8'd200, ALU_SLT, 1'b0, 8'd1, 1'b0, 1'b0},
               '{8'd200, 8'd3,   ALU_SLT, 1'b0, 8'd0, 1'b0, 1'b1},
               '{8'd77,  8'd77,  ALU_SLT, 1'b0, 8'd0, 1'b0, 1'b1}};
        foreach (tv[i]) begin
            apply(tv[i].a, tv[i].b, tv[i].op, tv[i].rs, from_vec(tv[i], $sformatf("slt%0d", i)));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (ALU_o !== e.r) begin errors++; $display("FAIL %s ALU_o got %0d want %0d", e.tag, ALU_o, e.r); end
            checks++; if (cout !== e.c) begin errors++; $display("FAIL %s cout got %b want %b", e.tag, cout, e.c); end
            checks++; if (zero !== e.z) begin errors++; $display("FAIL %s zero got %b want %b", e.tag, zero, e.z); end
        end
    endtask

    task automatic test_logic();
        vec_t tv[4];
        exp_t e;
        tv = '{'{8'hF0, 8'h3C, ALU_AND, 1'b0, 8'h30, 1'b0, 1'b0},
               '{8'hF0, 8'h3C, ALU_OR,  1'b0, 8'hFC, 1'b0, 1'b0},
               '{8'hF0, 8'h3C, ALU_NOR, 1'b0, 8'h03, 1'b0, 1'b0},
               '{8'hF0, 8'h0F, ALU_NOR, 1'b0, 8'h00, 1'b0, 1'b1}};
        foreach (tv[i]) begin
            apply(tv[i].a, tv[i].b, tv[i].op, tv[i].rs, from_vec(tv[i], $sformatf("logic%0d", i)));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (ALU_o !== e.r) begin errors++; $display("FAIL %s ALU_o got %0h want %0h", e.tag, ALU_o, e.r); end
            checks++; if (cout !== e.c) begin errors++; $display("FAIL %s cout got %b want %b", e.tag, cout, e.c); end
            checks++; if (zero !== e.z) begin errors++; $display("FAIL %s zero got %b want %b", e.tag, zero, e.z); end
        end
    endtask

    task automatic test_rst_priority();
        vec_t tv[3];
        exp_t e;
        tv = '{'{8'd255, 8'd1,  ALU_ADD, 1'b1, 8'd0, 1'b0, 1'b1},
               '{8'd255, 8'd1,  ALU_ADD, 1'b0, 8'd0, 1'b1, 1'b1},
               '{8'hFF,  8'hFF, 4'd4,    1'b0, 8'd0, 1'b0, 1'b1}};
        foreach (tv[i]) begin
            apply(tv[i].a, tv[i].b, tv[i].op, tv[i].rs, from_vec(tv[i], $sformatf("rstprio%0d", i)));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (ALU_o !== e.r) begin errors++; $display("FAIL %s ALU_o got %0d want %0d", e.tag, ALU_o, e.r); end
            checks++; if (cout !== e.c) begin errors++; $display("FAIL %s cout got %b want %b", e.tag, cout, e.c); end
            checks++; if (zero !== e.z) begin errors++; $display("FAIL %s zero got %b want %b", e.tag, zero, e.z); end
        end
    endtask

    // Back-to-back random traffic over the legal opcodes, one op per cycle.
    task automatic test_back_to_back();
        logic [3:0] ops[6];
        logic [W-1:0] a, b;
        logic [3:0] op;
        exp_t e;
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
        for (int i = 0; i < 1000; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = ops[$urandom_range(0, 5)];
            apply(a, b, op, 1'b0, model(a, b, op));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (ALU_o !== e.r || cout !== e.c || zero !== e.z) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%0d b=%0d got %0d/%b/%b want %0d/%b/%b",
                         i, op, a, b, ALU_o, cout, zero, e.r, e.c, e.z);
            end
        end
    endtask

    initial begin
        rst = 1'b1; A = '0; B = '0; ALU_ctrl = '0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_rst_priority();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
